dmem_window_ctrl: RTL and testbench
===================================

# dmem_window_ctrl

Data-memory responder for the EX stage. It owns a local window of 2^AW words of data memory and publishes the window bounds on DMEM_Base_Addr/DMEM_High_Addr. It serves loads combinationally on DMEM_DATA_WB_w and absorbs stores. When the core raises DMEM_no_hit, it writes back a dirty window and refills the window from external memory over a req/ack word interface.

## Interface
- AW, 4: log2 of window size; WORDS = 2^AW words.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- DMEM_WE  in  1  store strobe from EX (registered there).
- DMEM_Addr  in  32  word address from EX.
- DMEM_Data  in  32  store data from EX.
- DMEM_no_hit  in  1  EX miss flag; the core is stalled while it is high.
- DMEM_DATA_WB_w  out  32  load data for the current DMEM_Addr.
- DMEM_Base_Addr  out  32  first word of the valid window.
- DMEM_High_Addr  out  32  last word of the valid window.
- EXT_Req  out  1  external word request.
- EXT_WE  out  1  1 = write beat, 0 = read beat.
- EXT_Addr  out  32  external word address.
- EXT_Wdata  out  32  write-beat data.
- EXT_Ack  in  1  beat complete; sampled on the clk edge.
- EXT_Rdata  in  32  read data; valid in the cycle EXT_Ack = 1.

## Operation
- Storage: mem[0..WORDS-1] x 32 bits, plus registers cur_base, new_base, dirty, idx[AW-1:0] and state.
- Window valid means state == IDLE and valid == 1. In that case Base = cur_base and High = cur_base + WORDS - 1.
- Otherwise Base = 32'hFFFFFFFF and High = 32'h00000000. This empty window makes every address miss, so the core stays stalled.
- Load path: DMEM_DATA_WB_w = mem[DMEM_Addr[AW-1:0]], combinational, in every state. The value is meaningful only when the address is inside the window.
- Store path: in IDLE, if DMEM_WE = 1 and DMEM_Addr is inside the valid window, then mem[offset] <= DMEM_Data and dirty <= 1. DMEM_WE is ignored in every other case.
- Miss detection: the miss trigger is state = IDLE, DMEM_no_hit = 1, and DMEM_Addr not inside the valid window.
  - On the trigger: new_base <= {DMEM_Addr[31:AW], AW'b0} and idx <= 0.
  - Next state is WB if valid && dirty, otherwise FILL.
- DMEM_no_hit = 1 with DMEM_Addr inside the window is not a trigger; it is the core's one-cycle re-check after a refill.
- States:
  - IDLE: serves loads and stores; transitions as above.
  - WB: EXT_Req = 1, EXT_WE = 1, EXT_Addr = cur_base + idx, EXT_Wdata = mem[idx].
    - On EXT_Ack: idx <= idx + 1.
    - On EXT_Ack with idx = WORDS-1: idx <= 0 and go to FILL.
  - FILL: EXT_Req = 1, EXT_WE = 0, EXT_Addr = new_base + idx.
    - On EXT_Ack: mem[idx] <= EXT_Rdata and idx <= idx + 1.
    - On EXT_Ack with idx = WORDS-1: cur_base <= new_base, valid <= 1, dirty <= 0, go to IDLE.
- Handshake:
  - EXT_Req, EXT_WE, EXT_Addr and EXT_Wdata stay stable until the edge at which EXT_Ack = 1.
  - After that edge, EXT_Req stays high and the next beat's address follows combinationally from idx.
  - EXT_Ack while EXT_Req = 0 is ignored.
- Address arithmetic is 32-bit. Aligned windows cannot overflow; a window at 32'hFFFFFFF0 (AW=4) has High = 32'hFFFFFFFF.

## Timing
- Reset values, all asserted asynchronously while rst = 0:
  - state = IDLE, valid = 0, dirty = 0, idx = 0, cur_base = 0, new_base = 0.
  - Outputs: Base = 32'hFFFFFFFF, High = 0, EXT_Req = 0, EXT_WE = 0, EXT_Addr = 0, EXT_Wdata = 0.
  - mem contents are not reset.
- Reset asserted mid-WB or mid-FILL: EXT_Req drops in the same instant, the in-flight beat is abandoned, and dirty data is lost.
- Clean miss with EXT_Ack held at 1:
  - Cycle 0: IDLE samples the trigger.
  - Cycles 1..WORDS: one FILL beat per cycle.
  - Cycle WORDS+1: valid window is published.
- Dirty miss adds WORDS WB cycles before FILL.
- Each EXT_Ack wait cycle adds exactly one cycle.
- Stores are written at the edge and are visible on DMEM_DATA_WB_w in the next cycle.

## Test plan
- Reset release with DMEM_no_hit = 1, DMEM_Addr = 0 and EXT_Ack = 1 → 16 read beats at addresses 0..15; Base = 0 and High = 15 from cycle 17; EXT_Req = 0 afterwards.
- After that fill (EXT_Rdata = addr*3), DMEM_Addr = 5 → DMEM_DATA_WB_w = 15. Store 32'hDEADBEEF to addr 5 → read returns 32'hDEADBEEF the next cycle, and no EXT_Req is raised.
- Dirty window [0..15], then miss at DMEM_Addr = 32'h123 → 16 write beats at 0..15 (word 5 = 32'hDEADBEEF), then 16 read beats at 32'h120..32'h12F; Base = 32'h120, High = 32'h12F.
- EXT_Ack toggles 1,0,1,0 during FILL → each beat holds its address until acked; FILL takes 2*WORDS cycles; data lands at the correct offsets.
- Cycle after refill with DMEM_no_hit still 1 and DMEM_Addr inside the window → no new miss is started and state stays IDLE.
- Store with DMEM_Addr outside the window, and store during FILL → mem is unchanged and dirty stays 0. rst pulse mid-FILL → EXT_Req is 0 immediately and Base = 32'hFFFFFFFF.

Source files
------------

// File: rtl/dmem_window_ctrl.sv
// dmem_window_ctrl: data-memory window for the EX stage.
// Holds 2^AW words locally, serves loads combinationally, absorbs stores,
// and on a core miss writes back a dirty window then refills it over a
// req/ack word interface.
module dmem_window_ctrl #(
    parameter int unsigned AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DMEM_WE,
    input  logic [31:0] DMEM_Addr,
    input  logic [31:0] DMEM_Data,
    input  logic        DMEM_no_hit,
    output logic [31:0] DMEM_DATA_WB_w,
    output logic [31:0] DMEM_Base_Addr,
    output logic [31:0] DMEM_High_Addr,
    output logic        EXT_Req,
    output logic        EXT_WE,
    output logic [31:0] EXT_Addr,
    output logic [31:0] EXT_Wdata,
    input  logic        EXT_Ack,
    input  logic [31:0] EXT_Rdata
);

    localparam int unsigned WORDS = 2 ** AW;

    typedef enum logic [1:0] {
        StIdle,
        StWb,
        StFill
    } state_e;

    state_e        state_q;
    logic          valid_q;
    logic          dirty_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   cur_base_q;
    logic [31:0]   new_base_q;

    logic [31:0]   mem [WORDS];

    logic          win_valid;
    logic          in_win;
    logic          store_hit;
    logic          miss_trig;
    logic          last_beat;
    logic          beat_done;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    // Window qualification and the decoded events the FSM acts on.
    always_comb begin
        win_valid = (state_q == StIdle) && valid_q;
        // cur_base is always aligned, so comparing the upper bits is exact.
        in_win    = win_valid && (DMEM_Addr[31:AW] == cur_base_q[31:AW]);
        store_hit = DMEM_WE && in_win;
        miss_trig = (state_q == StIdle) && DMEM_no_hit && !in_win;
        last_beat = (idx_q == AW'(WORDS - 1));
        beat_done = EXT_Req && EXT_Ack;
    end

    // Published window bounds and load data.
    always_comb begin
        DMEM_DATA_WB_w = mem[DMEM_Addr[AW-1:0]];
        if (win_valid) begin
            DMEM_Base_Addr = cur_base_q;
            DMEM_High_Addr = cur_base_q + 32'(WORDS - 1);
        end else begin
            DMEM_Base_Addr = 32'hFFFF_FFFF;
            DMEM_High_Addr = 32'h0000_0000;
        end
    end

    // External beat signals decoded from state and idx only, so they hold
    // steady until the acking edge.
    always_comb begin
        EXT_Req   = 1'b0;
        EXT_WE    = 1'b0;
        EXT_Addr  = 32'h0;
        EXT_Wdata = 32'h0;
        unique case (state_q)
            StWb: begin
                EXT_Req   = 1'b1;
                EXT_WE    = 1'b1;
                EXT_Addr  = cur_base_q + 32'(idx_q);
                EXT_Wdata = mem[idx_q];
            end
            StFill: begin
                EXT_Req  = 1'b1;
                EXT_Addr = new_base_q + 32'(idx_q);
            end
            default: ;
        endcase
    end

    // Single memory write port shared by core stores and refill beats.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = DMEM_Addr[AW-1:0];
        mem_wdata = DMEM_Data;
        if (store_hit) begin
            mem_we = 1'b1;
        end else if ((state_q == StFill) && beat_done) begin
            mem_we    = 1'b1;
            mem_waddr = idx_q;
            mem_wdata = EXT_Rdata;
        end
    end

    // Window storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM: idle/store tracking, write-back and refill sequencing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            valid_q    <= 1'b0;
            dirty_q    <= 1'b0;
            idx_q      <= '0;
            cur_base_q <= 32'h0;
            new_base_q <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (store_hit) begin
                        dirty_q <= 1'b1;
                    end
                    if (miss_trig) begin
                        new_base_q <= {DMEM_Addr[31:AW], {AW{1'b0}}};
                        idx_q      <= '0;
                        state_q    <= (valid_q && dirty_q) ? StWb : StFill;
                    end
                end
                StWb: begin
                    if (beat_done) begin
                        idx_q <= idx_q + 1'b1;
                        if (last_beat) begin
                            idx_q   <= '0;
                            state_q <= StFill;
                        end
                    end
                end
                StFill: begin
                    if (beat_done) begin
                        idx_q <= idx_q + 1'b1;
                        if (last_beat) begin
                            cur_base_q <= new_base_q;
                            valid_q    <= 1'b1;
                            dirty_q    <= 1'b0;
                            state_q    <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_window_ctrl.sv
// Scoreboard bench for dmem_window_ctrl: directed stimulus pushes expected
// external beats into a queue; a monitor pops and compares every acked beat.
module tb_dmem_window_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data;
    logic        dmem_no_hit;
    logic [31:0] dmem_rd;
    logic [31:0] base_addr;
    logic [31:0] high_addr;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_ack;
    logic [31:0] ext_rdata;
    logic [31:0] rd_mul;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    // External memory model: read data is a fixed function of the address.
    assign ext_rdata = ext_addr * rd_mul;

    dmem_window_ctrl #(.AW(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .DMEM_WE        (dmem_we),
        .DMEM_Addr      (dmem_addr),
        .DMEM_Data      (dmem_data),
        .DMEM_no_hit    (dmem_no_hit),
        .DMEM_DATA_WB_w (dmem_rd),
        .DMEM_Base_Addr (base_addr),
        .DMEM_High_Addr (high_addr),
        .EXT_Req        (ext_req),
        .EXT_WE         (ext_we),
        .EXT_Addr       (ext_addr),
        .EXT_Wdata      (ext_wdata),
        .EXT_Ack        (ext_ack),
        .EXT_Rdata      (ext_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        beat_t b;
        b.we    = we;
        b.addr  = addr;
        b.wdata = wd;
        exp_q.push_back(b);
    endtask

    // Tick until the requested window is published; n counts the edges.
    task automatic wait_window(input logic [31:0] base, input bit toggle, output int n);
        n = 0;
        while (base_addr !== base && n < 200) begin
            tick();
            n++;
            if (toggle) ext_ack = ~ext_ack;
        end
    endtask

    // Monitor: every beat accepted at the next edge must match the queue head.
    always @(negedge clk) begin
        if (rst && ext_req && ext_ack) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got we=%b addr=%h expected none", ext_we, ext_addr);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                if (ext_we !== b.we || ext_addr !== b.addr || (b.we && ext_wdata !== b.wdata)) begin
                    bad++;
                    $display("FAIL beat: got we=%b addr=%h wd=%h expected we=%b addr=%h wd=%h",
                             ext_we, ext_addr, ext_wdata, b.we, b.addr, b.wdata);
                end
            end
        end
    end

    initial begin
        int n;
        rst         = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = 32'h0;
        dmem_data   = 32'h0;
        dmem_no_hit = 1'b1;
        ext_ack     = 1'b1;
        rd_mul      = 32'd3;
        tick();
        tick();
        check("rst_base", base_addr, 32'hFFFF_FFFF);
        check("rst_high", high_addr, 32'h0);
        check("rst_req", 32'(ext_req), 32'h0);
        check("rst_we", 32'(ext_we), 32'h0);
        check("rst_addr", ext_addr, 32'h0);
        check("rst_wdata", ext_wdata, 32'h0);

        // Clean fill of [0..15] straight out of reset.
        for (int i = 0; i < 16; i++) push_beat(1'b0, 32'(i), 32'h0);
        rst = 1'b1;
        wait_window(32'h0, 1'b0, n);
        check("fill0_cycles", 32'(n), 32'd17);
        check("fill0_high", high_addr, 32'd15);
        check("fill0_req", 32'(ext_req), 32'h0);

        // Re-check cycle: no_hit still high but address inside the window.
        tick();
        check("recheck_req", 32'(ext_req), 32'h0);
        check("recheck_base", base_addr, 32'h0);
        dmem_no_hit = 1'b0;

        dmem_addr = 32'd5;
        #1;
        check("load5", dmem_rd, 32'd15);

        // Store outside the window must not touch mem[1].
        dmem_addr = 32'h41;
        dmem_data = 32'h1234;
        dmem_we   = 1'b1;
        tick();
        dmem_we = 1'b0;
        #1;
        check("store_out_mem", dmem_rd, 32'd3);

        // Store inside the window.
        dmem_addr = 32'd5;
        dmem_data = 32'hDEAD_BEEF;
        dmem_we   = 1'b1;
        tick();
        dmem_we = 1'b0;
        #1;
        check("store5", dmem_rd, 32'hDEAD_BEEF);
        check("store_req", 32'(ext_req), 32'h0);

        // Dirty miss: write back [0..15] then refill [0x120..0x12F].
        for (int i = 0; i < 16; i++)
            push_beat(1'b1, 32'(i), (i == 5) ? 32'hDEAD_BEEF : 32'(i * 3));
        for (int i = 0; i < 16; i++) push_beat(1'b0, 32'h120 + 32'(i), 32'h0);
        dmem_addr   = 32'h123;
        dmem_no_hit = 1'b1;
        wait_window(32'h120, 1'b0, n);
        check("dirty_cycles", 32'(n), 32'd33);
        check("dirty_high", high_addr, 32'h12F);
        check("dirty_load", dmem_rd, 32'h123 * 3);
        dmem_no_hit = 1'b0;
        tick();

        // Clean miss with toggling ack and a store held during the fill.
        rd_mul = 32'd5;
        for (int i = 0; i < 16; i++) push_beat(1'b0, 32'h200 + 32'(i), 32'h0);
        dmem_addr   = 32'h205;
        dmem_data   = 32'hAAAA;
        dmem_we     = 1'b1;
        dmem_no_hit = 1'b1;
        ext_ack     = 1'b1;
        wait_window(32'h200, 1'b1, n);
        dmem_we     = 1'b0;
        dmem_no_hit = 1'b0;
        ext_ack     = 1'b1;
        check("toggle_cycles", 32'(n), 32'd33);
        check("toggle_high", high_addr, 32'h20F);
        #1;
        check("toggle_load5", dmem_rd, 32'h205 * 5);
        dmem_addr = 32'h20F;
        #1;
        check("toggle_load15", dmem_rd, 32'h20F * 5);
        dmem_addr = 32'h200;
        #1;
        check("toggle_load0", dmem_rd, 32'h200 * 5);

        // Window is clean, so this miss goes straight to FILL; reset it midway.
        for (int i = 0; i < 3; i++) push_beat(1'b0, 32'h500 + 32'(i), 32'h0);
        dmem_addr   = 32'h503;
        dmem_no_hit = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("midfill_req", 32'(ext_req), 32'h1);
        check("midfill_addr", ext_addr, 32'h503);
        rst = 1'b0;
        #1;
        check("rstfill_req", 32'(ext_req), 32'h0);
        check("rstfill_base", base_addr, 32'hFFFF_FFFF);
        check("rstfill_high", high_addr, 32'h0);
        tick();
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
